dt_bin2bcd_converter: RTL
=========================

Name: dt_bin2bcd_converter

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the digital tube display device. It takes a 32-bit binary word (signed or unsigned) and produces 8 packed BCD digits plus a sign code. Software or a bridge then writes these to the display's number and sign registers, so the tubes show decimal rather than hex. It uses the shift-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake.

Parameters:
NEG_CODE, 8'h01, value driven on sign_out when the converted input was negative
POS_CODE, 8'h00, value driven on sign_out when the input was non-negative

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  request conversion; sampled only in IDLE
signed_mode  input  1  1: bin_in is two's complement; 0: unsigned; sampled with start
bin_in  input  32  binary value; sampled with start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; results valid and updated
bcd_out  output  32  8 BCD digits, [3:0] is the least significant
sign_out  output  8  NEG_CODE or POS_CODE
overflow  output  1  magnitude >= 100000000, so digits 9-10 were nonzero

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, sign_out=POS_CODE, overflow=0, and internal shift/BCD registers and counter are 0. A reset mid-conversion aborts with no done pulse.
- States are IDLE, SHIFT and DONE.
- IDLE: on the edge E0 where start=1:
  - Latch magnitude: if signed_mode and bin_in[31], magnitude = (~bin_in)+1 as a 32-bit unsigned value (0x80000000 gives 2147483648). Otherwise magnitude = bin_in.
  - Latch the neg flag.
  - Clear the 40-bit internal BCD accumulator (10 digits) and set the counter to 31.
  - Go to SHIFT.
- SHIFT: each edge does the following:
  - Add 3 to every accumulator digit >= 5.
  - Shift {accumulator, magnitude} left by 1.
  - Decrement the counter.
  - Exactly 32 shift edges occur, E1..E32.
- At E32:
  - bcd_out <= lower 8 digits of the final accumulator.
  - overflow <= (upper 2 digits != 0).
  - sign_out <= neg ? NEG_CODE : POS_CODE.
  - State becomes DONE.
- DONE: done=1 for exactly the cycle between E32 and E33. At E33 the state returns to IDLE. start is ignored in DONE.
- busy=1 exactly in SHIFT, i.e. from E0 to E32. busy=0 in IDLE and DONE. busy and done are never both 1.
- Latency: done rises 32 edges after the start-accepting edge. Minimum back-to-back period is 34 cycles.
- start while busy or in DONE: ignored, with no queueing. Changes to bin_in or signed_mode after E0 have no effect.
- Outputs bcd_out, sign_out and overflow hold their last result until the next E32. They are not cleared by a new start.
- Signed zero gives POS_CODE. Unsigned inputs never give NEG_CODE.
- Every digit of bcd_out is always a legal BCD value (0-9).

Optional Feature:
BIN2BCD_SATURATE_EN:
- Defined: at E32, if overflow, bcd_out <= 32'h99999999, with overflow=1 and sign_out unchanged.
- Undefined: bcd_out holds the truncated lower 8 digits.
- All other behaviour is identical in both builds.

Test Plan:
- Reset released; start=1, signed_mode=0, bin_in=32'h00BC614E (12345678) -> done pulse 32 edges after acceptance; bcd_out=32'h12345678, overflow=0, sign_out=POS_CODE; busy=1 for exactly 32 cycles.
- signed_mode=1, bin_in=32'hFFFFFFFF (-1) -> bcd_out=32'h00000001, sign_out=NEG_CODE, overflow=0.
- signed_mode=1, bin_in=32'h80000000 -> overflow=1, sign_out=NEG_CODE; bcd_out=32'h47483648, or 32'h99999999 with BIN2BCD_SATURATE_EN.
- signed_mode=0, bin_in=32'hFFFFFFFF (4294967295) -> overflow=1, sign_out=POS_CODE; bcd_out=32'h94967295, or 32'h99999999 with BIN2BCD_SATURATE_EN.
- Start 0x00000063 (99); pulse start with bin_in=0x00000001 at cycles 5 and 32 (busy) and in the DONE cycle -> a single done pulse, bcd_out=32'h00000099; a next start in IDLE converts normally.
- Start a conversion, assert reset=0 asynchronously at cycle 15 (mid-clock) -> busy, done, bcd_out and overflow go to 0 and sign_out to POS_CODE immediately; no done pulse; after release, 32'd0 converts to bcd_out=0.

Source files
------------

// File: rtl/dt_bin2bcd_converter.sv
// Sequential 32-bit binary (signed/unsigned) to 8-digit packed BCD converter using shift-add-3.
// Optional build macro BIN2BCD_SATURATE_EN: on overflow bcd_out saturates to 32'h99999999.
module dt_bin2bcd_converter #(
    parameter logic [7:0] NEG_CODE = 8'h01,
    parameter logic [7:0] POS_CODE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_mode,
    input  logic [31:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd_out,
    output logic [7:0]  sign_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [39:0] add3_digits(input logic [39:0] acc);
        logic [39:0] res;
        res = acc;
        for (int i = 0; i < 10; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] mag_q, mag_d;
    logic [39:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] bcd_q, bcd_d;
    logic [7:0]  sign_q, sign_d;
    logic        ovf_q, ovf_d;

    logic        load_s;
    logic        last_s;
    logic        neg_in_s;
    logic [31:0] mag_in_s;
    logic [39:0] acc_adj_s;
    logic [39:0] acc_next_s;
    logic [31:0] mag_next_s;

    // State and handshake register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
                else       state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt_q == 5'd0) state_d = ST_DONE;
                else               state_d = ST_SHIFT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the upcoming state
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_SHIFT: busy_d = 1'b1;
            ST_DONE:  done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, one add-3/shift step per cycle, result update on the last step
    always_comb begin
        load_s     = (state_q == ST_IDLE) && start;
        last_s     = (state_q == ST_SHIFT) && (cnt_q == 5'd0);
        neg_in_s   = signed_mode & bin_in[31];
        mag_in_s   = neg_in_s ? (~bin_in + 32'd1) : bin_in;
        acc_adj_s  = add3_digits(acc_q);
        acc_next_s = {acc_adj_s[38:0], mag_q[31]};
        mag_next_s = {mag_q[30:0], 1'b0};

        mag_d  = mag_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        bcd_d  = bcd_q;
        sign_d = sign_q;
        ovf_d  = ovf_q;

        if (load_s) begin
            mag_d = mag_in_s;
            acc_d = 40'd0;
            cnt_d = 5'd31;
            neg_d = neg_in_s;
        end else if (state_q == ST_SHIFT) begin
            mag_d = mag_next_s;
            acc_d = acc_next_s;
            cnt_d = (cnt_q == 5'd0) ? 5'd0 : (cnt_q - 5'd1);
        end else begin
            mag_d = mag_q;
            acc_d = acc_q;
        end

        if (last_s) begin
            ovf_d  = (acc_next_s[39:32] != 8'd0);
            sign_d = neg_q ? NEG_CODE : POS_CODE;
`ifdef BIN2BCD_SATURATE_EN
            bcd_d  = ovf_d ? 32'h9999_9999 : acc_next_s[31:0];
`else
            bcd_d  = acc_next_s[31:0];
`endif
        end else begin
            bcd_d = bcd_q;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_q  <= 32'd0;
            acc_q  <= 40'd0;
            cnt_q  <= 5'd0;
            neg_q  <= 1'b0;
            bcd_q  <= 32'd0;
            sign_q <= POS_CODE;
            ovf_q  <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            bcd_q  <= bcd_d;
            sign_q <= sign_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign sign_out = sign_q;
    assign overflow = ovf_q;

endmodule
